// File: rtl/echo_delay_ctrl.sv
// Echo/delay controller: one dry sample in, one read and one write to an external
// dual-port delay RAM, one processed sample out, every three clocks at most.
module echo_delay_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  output logic                         in_ready,
  input  logic        [ADDR_WIDTH-1:0] delay_len,
  input  logic        [7:0]            fb_gain,
  input  logic        [7:0]            mix_gain,
  output logic        [ADDR_WIDTH-1:0] mem_addr_a,
  output logic signed [DATA_WIDTH-1:0] mem_data_a,
  output logic                         mem_we_a,
  output logic        [ADDR_WIDTH-1:0] mem_addr_b,
  output logic                         mem_we_b,
  input  logic signed [DATA_WIDTH-1:0] mem_q_b,
  output logic signed [DATA_WIDTH-1:0] sample_out,
  output logic                         out_valid,
  output logic                         overrun
);

  localparam int PW = DATA_WIDTH + 9;
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, READ, CALC} state_t;

  state_t state, next_state;

  logic signed [DATA_WIDTH-1:0] x_q;
  logic        [ADDR_WIDTH-1:0] dly_q;
  logic        [7:0]            fb_q;
  logic        [7:0]            mix_q;
  logic                         en_q;
  logic        [ADDR_WIDTH-1:0] wr_ptr;

  logic signed [PW-1:0]         d_ext;
  logic signed [PW-1:0]         fb_prod;
  logic signed [PW-1:0]         mix_prod;
  logic signed [DATA_WIDTH-1:0] fb_val;
  logic signed [DATA_WIDTH-1:0] wet_val;
  logic        [DATA_WIDTH:0]   fb_sum;
  logic        [DATA_WIDTH:0]   wet_sum;
  logic signed [DATA_WIDTH-1:0] fb_res;
  logic signed [DATA_WIDTH-1:0] wet_res;

  // Clamp a one-bit-wider sum back into the signed sample range.
  function automatic logic [DATA_WIDTH-1:0] sat(input logic [DATA_WIDTH:0] s);
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      if (s[DATA_WIDTH]) begin
        return SAT_MIN;
      end else begin
        return SAT_MAX;
      end
    end else begin
      return s[DATA_WIDTH-1:0];
    end
  endfunction

  // Gains are unsigned Q0.8, so they enter the signed multiply with a zero sign bit.
  assign d_ext    = {{9{mem_q_b[DATA_WIDTH-1]}}, mem_q_b};
  assign fb_prod  = d_ext * $signed({{(DATA_WIDTH+1){1'b0}}, fb_q});
  assign mix_prod = d_ext * $signed({{(DATA_WIDTH+1){1'b0}}, mix_q});
  assign fb_val   = DATA_WIDTH'(fb_prod >>> 8);
  assign wet_val  = DATA_WIDTH'(mix_prod >>> 8);
  assign fb_sum   = {x_q[DATA_WIDTH-1], x_q} + {fb_val[DATA_WIDTH-1], fb_val};
  assign wet_sum  = {x_q[DATA_WIDTH-1], x_q} + {wet_val[DATA_WIDTH-1], wet_val};
  assign fb_res   = sat(fb_sum);
  assign wet_res  = sat(wet_sum);

  assign mem_we_b = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sample_valid) next_state = READ;
      READ:    next_state = CALC;
      CALC:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // RAM strobes are decoded from state so a reset drops them the same instant.
  always_comb begin
    in_ready   = 1'b0;
    mem_we_a   = 1'b0;
    mem_addr_a = '0;
    mem_data_a = '0;
    mem_addr_b = '0;
    case (state)
      IDLE: in_ready = 1'b1;
      READ: mem_addr_b = wr_ptr - dly_q;
      CALC: begin
        mem_we_a   = 1'b1;
        mem_addr_a = wr_ptr;
        mem_data_a = en_q ? fb_res : x_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      dly_q      <= '0;
      fb_q       <= '0;
      mix_q      <= '0;
      en_q       <= 1'b0;
      wr_ptr     <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE && sample_valid) begin
        x_q   <= sample_in;
        dly_q <= delay_len;
        fb_q  <= fb_gain;
        mix_q <= mix_gain;
        en_q  <= enable;
      end
      if (state == CALC) begin
        sample_out <= en_q ? wet_res : x_q;
        out_valid  <= 1'b1;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (state != IDLE && sample_valid) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_echo_delay_ctrl.sv
// Self-checking bench for echo_delay_ctrl: behavioural delay-RAM plus an
// arithmetic echo model, directed cases followed by randomized traffic.
module tb_echo_delay_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 enable;
  logic                 sample_valid;
  logic signed [DW-1:0] sample_in;
  logic                 in_ready;
  logic        [AW-1:0] delay_len;
  logic        [7:0]    fb_gain;
  logic        [7:0]    mix_gain;
  logic        [AW-1:0] mem_addr_a;
  logic signed [DW-1:0] mem_data_a;
  logic                 mem_we_a;
  logic        [AW-1:0] mem_addr_b;
  logic                 mem_we_b;
  logic signed [DW-1:0] mem_q_b;
  logic signed [DW-1:0] sample_out;
  logic                 out_valid;
  logic                 overrun;

  logic signed [DW-1:0] ram [DEPTH] = '{default: '0};
  logic signed [DW-1:0] ram_q = '0;

  int model_mem [DEPTH] = '{default: 0};
  int model_ptr = 0;
  bit exp_overrun = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  echo_delay_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_valid(sample_valid),
    .sample_in(sample_in), .in_ready(in_ready), .delay_len(delay_len),
    .fb_gain(fb_gain), .mix_gain(mix_gain), .mem_addr_a(mem_addr_a),
    .mem_data_a(mem_data_a), .mem_we_a(mem_we_a), .mem_addr_b(mem_addr_b),
    .mem_we_b(mem_we_b), .mem_q_b(mem_q_b), .sample_out(sample_out),
    .out_valid(out_valid), .overrun(overrun)
  );

  // External dual-port RAM with a registered read port.
  always @(posedge clk) begin
    if (mem_we_a) ram[mem_addr_a] <= mem_data_a;
    ram_q <= ram[mem_addr_b];
  end
  assign mem_q_b = ram_q;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // floor(d * g / 256) computed with exact integer arithmetic
  function automatic int q8_scale(input int d, input int g);
    int p, r;
    p = d * g;
    r = p % 256;
    if (r < 0) r += 256;
    return (p - r) / 256;
  endfunction

  task automatic model_step(input int x, input int dl, input int fbg, input int mixg,
                            input bit en, output int out, output int wdata,
                            output int raddr, output int waddr);
    int dlen, d;
    dlen  = (dl == 0) ? DEPTH : dl;
    raddr = (model_ptr - dlen + DEPTH) % DEPTH;
    d     = model_mem[raddr];
    if (en) begin
      wdata = sat16(x + q8_scale(d, fbg));
      out   = sat16(x + q8_scale(d, mixg));
    end else begin
      wdata = x;
      out   = x;
    end
    waddr = model_ptr;
    model_mem[model_ptr] = wdata;
    model_ptr = (model_ptr + 1) % DEPTH;
  endtask

  // Starts and ends at a falling edge with the DUT idle.
  task automatic do_sample(input int x, input int dl, input int fbg, input int mixg,
                           input bit en);
    int out, wdata, raddr, waddr;
    model_step(x, dl, fbg, mixg, en, out, wdata, raddr, waddr);
    sample_valid = 1'b1;
    sample_in    = DW'(x);
    delay_len    = AW'(dl);
    fb_gain      = 8'(fbg);
    mix_gain     = 8'(mixg);
    enable       = en;
    @(posedge clk); @(negedge clk);
    sample_valid = 1'b0;
    sample_in    = DW'($urandom);
    delay_len    = AW'($urandom);
    fb_gain      = 8'($urandom);
    mix_gain     = 8'($urandom);
    enable       = 1'($urandom);
    check("read_in_ready", 32'(in_ready), 0);
    check("read_addr_b", 32'(mem_addr_b), raddr);
    check("read_we_a", 32'(mem_we_a), 0);
    @(posedge clk); @(negedge clk);
    check("calc_we_a", 32'(mem_we_a), 1);
    check("calc_addr_a", 32'(mem_addr_a), waddr);
    check("calc_data_a", 32'(mem_data_a), wdata);
    check("calc_out_valid", 32'(out_valid), 0);
    @(posedge clk); @(negedge clk);
    check("out_valid", 32'(out_valid), 1);
    check("sample_out", 32'(sample_out), out);
    check("done_in_ready", 32'(in_ready), 1);
    check("overrun", 32'(overrun), 32'(exp_overrun));
    check("we_b", 32'(mem_we_b), 0);
  endtask

  initial begin
    int echo_in [6]  = '{1000, 0, 0, 0, 0, 0};
    int echo_exp [6] = '{1000, 0, 0, 0, 500, 0};
    int bb_out [3];
    int bb_w, bb_ra, bb_wa, addr, old_val;

    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = '0;
    delay_len = '0; fb_gain = '0; mix_gain = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sample_out", 32'(sample_out), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_we_a", 32'(mem_we_a), 0);
    check("rst_addr_a", 32'(mem_addr_a), 0);
    check("rst_addr_b", 32'(mem_addr_b), 0);
    check("rst_data_a", 32'(mem_data_a), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 32'(in_ready), 1);

    // Single echo tap at delay 4 with half gain.
    for (int i = 0; i < 6; i++) begin
      do_sample(echo_in[i], 4, 128, 128, 1'b1);
      check("echo_table", 32'(sample_out), echo_exp[i]);
    end
    check("echo_ram4", 32'(ram[4]), 500);

    // Saturation at both rails.
    do_sample(32767, 1, 0, 0, 1'b0);
    do_sample(32767, 1, 255, 255, 1'b1);
    check("sat_pos", 32'(sample_out), 32767);
    do_sample(-32768, 1, 0, 0, 1'b0);
    do_sample(-32768, 1, 255, 255, 1'b1);
    check("sat_neg", 32'(sample_out), -32768);

    // Bypass ignores gains but still writes the dry sample.
    addr = model_ptr;
    do_sample(-1234, $urandom_range(255), $urandom_range(255), $urandom_range(255), 1'b0);
    check("bypass_out", 32'(sample_out), -1234);
    check("bypass_ram", 32'(ram[addr]), -1234);
    @(posedge clk); @(negedge clk);
    check("hold_valid", 32'(out_valid), 0);
    check("hold_out", 32'(sample_out), -1234);

    // Full-depth delay across the pointer wrap.
    for (int i = 0; i < 300; i++) begin
      do_sample(int'($signed(16'($urandom))), 0, $urandom_range(255),
                $urandom_range(255), ($urandom_range(3) != 0));
    end

    for (int i = 0; i < 120; i++) begin
      do_sample(int'($signed(16'($urandom))), $urandom_range(255), $urandom_range(255),
                $urandom_range(255), ($urandom_range(3) != 0));
    end

    // sample_valid held high: one acceptance every third cycle.
    sample_valid = 1'b1; sample_in = 16'sd777; delay_len = 8'd3;
    fb_gain = 8'd100; mix_gain = 8'd200; enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0) model_step(777, 3, 100, 200, 1'b1, bb_out[k/3], bb_w, bb_ra, bb_wa);
      @(posedge clk); @(negedge clk);
      check("b2b_in_ready", 32'(in_ready), 32'(k % 3 == 2));
      check("b2b_out_valid", 32'(out_valid), 32'(k % 3 == 2));
      check("b2b_we_a", 32'(mem_we_a), 32'(k % 3 == 1));
      check("b2b_overrun", 32'(overrun), 32'(k >= 1));
      if (k % 3 == 2) check("b2b_sample_out", 32'(sample_out), bb_out[k/3]);
    end
    sample_valid = 1'b0;
    exp_overrun = 1'b1;
    do_sample(-5, 7, 10, 20, 1'b1);

    // Reset while the write is in flight.
    addr = model_ptr;
    old_val = int'(ram[addr]);
    sample_valid = 1'b1; sample_in = 16'sd4321; delay_len = 8'd2; enable = 1'b1;
    @(posedge clk); @(negedge clk);
    sample_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_we_before", 32'(mem_we_a), 1);
    rst_n = 1'b0;
    #1;
    check("abort_we_a", 32'(mem_we_a), 0);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_overrun", 32'(overrun), 0);
    @(posedge clk); @(negedge clk);
    check("abort_ram", 32'(ram[addr]), old_val);
    rst_n = 1'b1;
    model_ptr = 0;
    exp_overrun = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_no_valid", 32'(out_valid), 0);
    check("abort_sample_out", 32'(sample_out), 0);
    for (int i = 0; i < 4; i++) begin
      do_sample(int'($signed(16'($urandom))), $urandom_range(255), $urandom_range(255),
                $urandom_range(255), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/echo_delay_ctrl.md
ECHO_DELAY_CTRL -- requirements
Module: echo_delay_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 16, signed sample width and memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, 8, delay-buffer address width; buffer depth is 2^ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock for all logic, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  1 = echo applied; 0 = bypass (dry sample out, dry sample still written to buffer).
REQ-006 SHALL have port sample_valid  input  1  sample_in is valid this cycle.
REQ-007 SHALL have port sample_in  input  DATA_WIDTH  signed two's-complement dry sample.
REQ-008 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-009 SHALL have port delay_len  input  ADDR_WIDTH  echo delay in samples; 0 means full depth 2^ADDR_WIDTH.
REQ-010 SHALL have port fb_gain  input  8  unsigned Q0.8 feedback gain applied to the delayed sample written back.
REQ-011 SHALL have port mix_gain  input  8  unsigned Q0.8 gain applied to the delayed sample added to the output.
REQ-012 SHALL have ports mem_addr_a (output, ADDR_WIDTH), mem_data_a (output, DATA_WIDTH) and mem_we_a (output, 1), which form the write port to the dual-port RAM.
REQ-013 SHALL have ports mem_addr_b (output, ADDR_WIDTH), mem_we_b (output, 1, constant 0) and mem_q_b (input, DATA_WIDTH), which form the read port; RAM read latency is 1 clock (registered q).
REQ-014 SHALL have port sample_out  output  DATA_WIDTH  signed processed sample.
REQ-015 SHALL have port out_valid  output  1  one-cycle pulse qualifying sample_out.
REQ-016 SHALL have port overrun  output  1  sticky flag set when sample_valid arrives while in_ready=0.

Function
REQ-017 SHALL implement FSM states IDLE, READ, CALC; in_ready=1 only in IDLE.
REQ-018 IDLE: on sample_valid=1, SHALL register sample_in, delay_len, fb_gain, mix_gain and enable, then go to READ; otherwise stay in IDLE.
REQ-019 READ: SHALL drive mem_addr_b = (wr_ptr - delay_len) mod 2^ADDR_WIDTH for exactly one cycle, then go to CALC.
REQ-020 CALC: SHALL take d = mem_q_b and compute fb = (d*fb_gain)>>>8 and wet = (d*mix_gain)>>>8 using signed products of DATA_WIDTH+9 bits and an arithmetic shift.
REQ-021 CALC: SHALL drive mem_we_a=1, mem_addr_a=wr_ptr, mem_data_a=sat(x+fb) for one cycle, where x is the registered sample; with registered enable=0, mem_data_a=x.
REQ-022 At the CALC edge, SHALL register sample_out=sat(x+wet) (enable=1) or x (enable=0), pulse out_valid for the following cycle, increment wr_ptr modulo 2^ADDR_WIDTH, and return to IDLE.
REQ-023 sat() SHALL form a DATA_WIDTH+1-bit sum and clamp it to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-024 Latency: with sample_valid accepted at edge E0, out_valid SHALL be high in exactly the cycle after edge E2; the maximum throughput is 1 sample per 3 cycles.
REQ-025 mem_we_a SHALL be 0 outside CALC; mem_we_b SHALL always be 0.
REQ-026 sample_valid while in_ready=0 SHALL be ignored and SHALL set overrun=1 until reset.
REQ-027 sample_out SHALL hold its value between out_valid pulses.
REQ-028 A delay_len change SHALL take effect only at the next accepted sample; wr_ptr wrap from 2^ADDR_WIDTH-1 to 0 SHALL be seamless.

Reset
REQ-029 With rst_n=0, asynchronously: state=IDLE, wr_ptr=0, sample_out=0, out_valid=0, overrun=0, mem_we_a=0, mem_addr_a=0, mem_addr_b=0, mem_data_a=0; in_ready=1 after release.
REQ-030 A reset asserted in READ or CALC SHALL abort the sample with no RAM write and no out_valid; RAM contents SHALL NOT be cleared by this block.

Verification
REQ-031 Zeroed RAM, delay_len=4, mix=fb=128, samples 1000,0,0,0,0,0 -> out 1000,0,0,0,500,0; RAM[4]=500.
REQ-032 Saturation: DATA_WIDTH=16, delayed value 32767, mix=255, x=32767 -> sample_out=32767; x=-32768 with delayed -32768 -> -32768.
REQ-033 Wrap: 300 samples with delay_len=0 -> wr_ptr wraps after 256, and sample 257 reads the location of sample 1.
REQ-034 Back-to-back: sample_valid held high -> accepted every 3rd cycle, overrun=1 after the first ignored cycle.
REQ-035 Reset asserted in CALC -> mem_we_a drops immediately, no out_valid, wr_ptr=0, in_ready=1 after release.
REQ-036 enable=0, x=-1234 -> sample_out=-1234 and RAM[wr_ptr]=-1234 regardless of gains.
